// File: rtl/rv32_instructions_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rv32_instructions_pkg
// Description : Shared RV32 pipeline types. Holds the instruction packet that
//               travels from issue to commit, and the reorder-buffer entry
//               and writeback packet types used by the IROB.
// Revision    : 1.1 - irob_tag widened to IROB_TAG_WIDTH; IROB types added
// ============================================================================
package rv32_instructions_pkg;

    // Default IROB geometry (64 entries -> 6-bit tag).
    localparam int IROB_DEPTH      = 64;
    localparam int IROB_TAG_WIDTH  = $clog2(IROB_DEPTH);
    localparam int IROB_DATA_WIDTH = 32;
    localparam int IROB_ADDR_WIDTH = 32;
    localparam int IROB_REG_WIDTH  = 5;
    localparam int IROB_EXC_WIDTH  = 4;

    // Decoded instruction as handed from issue towards execution.
    typedef struct packed {
        logic [IROB_ADDR_WIDTH-1:0] addr;
        logic [31:0]                instr;
        logic [IROB_REG_WIDTH-1:0]  reg_dest;
        logic [IROB_TAG_WIDTH-1:0]  irob_tag;
    } instr_packet_t;

    // One reorder-buffer slot.
    typedef struct packed {
        logic                        valid;
        logic                        done;
        logic [IROB_ADDR_WIDTH-1:0]  addr;
        logic [IROB_REG_WIDTH-1:0]   reg_dest;
        logic [IROB_DATA_WIDTH-1:0]  result;
        logic                        exception;
        logic [IROB_EXC_WIDTH-1:0]   exc_vector;
    } irob_entry_t;

    // Result returned by one execution unit.
    typedef struct packed {
        logic [IROB_TAG_WIDTH-1:0]   tag;
        logic [IROB_DATA_WIDTH-1:0]  result;
        logic                        exception;
        logic [IROB_EXC_WIDTH-1:0]   exc_vector;
    } irob_wb_packet_t;

endpackage
`default_nettype wire

// File: rtl/instruction_reorder_buffer_wb_resolver.sv
`default_nettype none
// ============================================================================
// Module      : irob_wb_resolver
// Description : Per-entry writeback decode. Scans all writeback channels for
//               one targeting this entry and produces a single write enable
//               plus the index of the winning channel (lowest index wins).
// Ports       : i_wb_valid    - per-channel valid
//               i_wb_tag      - per-channel target tags, flattened
//               i_entry_valid - entry currently allocated
//               o_we          - entry must capture a result this cycle
//               o_sel         - channel whose result is captured
// Revision    : 1.0 - initial release
// ============================================================================
module irob_wb_resolver #(
    parameter int WB_PORTS  = 4,
    parameter int TAG_WIDTH = 6,
    parameter int ENTRY_IDX = 0,
    parameter int SEL_WIDTH = 2
) (
    input  wire logic [WB_PORTS-1:0]           i_wb_valid,
    input  wire logic [WB_PORTS*TAG_WIDTH-1:0] i_wb_tag,
    input  wire logic                          i_entry_valid,
    output logic                               o_we,
    output logic [SEL_WIDTH-1:0]               o_sel
);

    localparam logic [TAG_WIDTH-1:0] c_IDX = TAG_WIDTH'(ENTRY_IDX);

    logic w_hit;

    // Scanned from the highest channel down so the lowest matching channel
    // is the last assignment and therefore wins.
    always_comb begin
        w_hit = 1'b0;
        o_sel = '0;
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (i_wb_valid[p] && (i_wb_tag[p*TAG_WIDTH +: TAG_WIDTH] == c_IDX)) begin
                w_hit = 1'b1;
                o_sel = SEL_WIDTH'(p);
            end
        end
    end

    // Results for unallocated entries are dropped.
    assign o_we = w_hit & i_entry_valid;

endmodule
`default_nettype wire

// File: rtl/instruction_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_reorder_buffer
// Description : Circular reorder buffer. Hands out tags in program order,
//               accepts out-of-order results on WB_PORTS channels and
//               retires the head entry in order once its result is present.
// Ports       : clk_i/rst_i             - clock, synchronous active-high reset
//               flush_i                 - discard every entry
//               alloc_*                 - issue-side allocation handshake
//               wb_*                    - per-channel result writeback
//               commit_*                - head entry and commit handshake
//               full_o/empty_o          - occupancy flags
// Revision    : 1.1 - configurable depth/channels, flush support
// ============================================================================
module instruction_reorder_buffer
    import rv32_instructions_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int TAG_WIDTH  = $clog2(DEPTH),
    parameter int DATA_WIDTH = 32,
    parameter int WB_PORTS   = 4
) (
    input  wire logic                               clk_i,
    input  wire logic                               rst_i,
    input  wire logic                               flush_i,
    // Allocation
    input  wire logic                               alloc_valid_i,
    output logic                                    alloc_ready_o,
    input  wire logic [IROB_ADDR_WIDTH-1:0]         alloc_addr_i,
    input  wire logic [IROB_REG_WIDTH-1:0]          alloc_reg_dest_i,
    output logic [TAG_WIDTH-1:0]                    alloc_tag_o,
    // Writeback
    input  wire logic [WB_PORTS-1:0]                wb_valid_i,
    input  wire logic [WB_PORTS*TAG_WIDTH-1:0]      wb_tag_i,
    input  wire logic [WB_PORTS*DATA_WIDTH-1:0]     wb_result_i,
    input  wire logic [WB_PORTS-1:0]                wb_exception_i,
    input  wire logic [WB_PORTS*IROB_EXC_WIDTH-1:0] wb_exc_vector_i,
    // Commit
    output logic                                    commit_valid_o,
    input  wire logic                               commit_ready_i,
    output logic [TAG_WIDTH-1:0]                    commit_tag_o,
    output logic [IROB_ADDR_WIDTH-1:0]              commit_addr_o,
    output logic [IROB_REG_WIDTH-1:0]               commit_reg_dest_o,
    output logic [DATA_WIDTH-1:0]                   commit_result_o,
    output logic                                    commit_exception_o,
    output logic [IROB_EXC_WIDTH-1:0]               commit_exc_vector_o,
    // Status
    output logic                                    full_o,
    output logic                                    empty_o
);

    localparam int                 c_SEL_WIDTH = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;
    localparam logic [TAG_WIDTH:0] c_DEPTH     = (TAG_WIDTH+1)'(DEPTH);

    // Pointer and occupancy state
    logic [TAG_WIDTH-1:0] r_head;
    logic [TAG_WIDTH-1:0] r_tail;
    logic [TAG_WIDTH:0]   r_count;

    // Entry storage: control bits are reset, payload is not
    logic [DEPTH-1:0]           r_valid;
    logic [DEPTH-1:0]           r_done;
    logic [IROB_ADDR_WIDTH-1:0] r_addr   [DEPTH];
    logic [IROB_REG_WIDTH-1:0]  r_dest   [DEPTH];
    logic [DATA_WIDTH-1:0]      r_result [DEPTH];
    logic [DEPTH-1:0]           r_exc;
    logic [IROB_EXC_WIDTH-1:0]  r_vec    [DEPTH];

    // Unpacked writeback channels
    logic [DATA_WIDTH-1:0]      w_wb_result [WB_PORTS];
    logic [IROB_EXC_WIDTH-1:0]  w_wb_vec    [WB_PORTS];

    // Per-entry writeback decode
    logic [DEPTH-1:0]           w_wb_we;
    logic [c_SEL_WIDTH-1:0]     w_wb_sel [DEPTH];

    logic w_alloc;
    logic w_commit;

    generate
        for (genvar p = 0; p < WB_PORTS; p++) begin : g_unpack
            assign w_wb_result[p] = wb_result_i[p*DATA_WIDTH +: DATA_WIDTH];
            assign w_wb_vec[p]    = wb_exc_vector_i[p*IROB_EXC_WIDTH +: IROB_EXC_WIDTH];
        end

        for (genvar e = 0; e < DEPTH; e++) begin : g_entry
            irob_wb_resolver #(
                .WB_PORTS  (WB_PORTS),
                .TAG_WIDTH (TAG_WIDTH),
                .ENTRY_IDX (e),
                .SEL_WIDTH (c_SEL_WIDTH)
            ) u_resolver (
                .i_wb_valid    (wb_valid_i),
                .i_wb_tag      (wb_tag_i),
                .i_entry_valid (r_valid[e]),
                .o_we          (w_wb_we[e]),
                .o_sel         (w_wb_sel[e])
            );
        end
    endgenerate

    // Status and handshakes. Reset and flush block both handshakes in the
    // cycle they are asserted, so nothing enters or leaves while the
    // buffer is being discarded.
    assign full_o         = (r_count == c_DEPTH);
    assign empty_o        = (r_count == '0);
    assign alloc_ready_o  = !full_o && !rst_i && !flush_i;
    assign alloc_tag_o    = r_tail;
    assign commit_valid_o = r_valid[r_head] && r_done[r_head] && !rst_i && !flush_i;

    assign w_alloc  = alloc_valid_i && alloc_ready_o;
    assign w_commit = commit_valid_o && commit_ready_i;

    assign commit_tag_o        = r_head;
    assign commit_addr_o       = r_addr[r_head];
    assign commit_reg_dest_o   = r_dest[r_head];
    assign commit_result_o     = r_result[r_head];
    assign commit_exception_o  = r_exc[r_head];
    assign commit_exc_vector_o = r_vec[r_head];

    // Control state
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_wb_we[e]) begin
                    r_done[e] <= 1'b1;
                end
            end
            // The tail slot is never valid when allocation is possible, so
            // it cannot collide with a writeback or with the head slot.
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage; stale contents are harmless because valid/done gate
    // every use.
    always_ff @(posedge clk_i) begin
        if (w_alloc) begin
            r_addr[r_tail] <= alloc_addr_i;
            r_dest[r_tail] <= alloc_reg_dest_i;
        end
        for (int e = 0; e < DEPTH; e++) begin
            if (w_wb_we[e]) begin
                r_result[e] <= w_wb_result[w_wb_sel[e]];
                r_exc[e]    <= wb_exception_i[w_wb_sel[e]];
                r_vec[e]    <= w_wb_vec[w_wb_sel[e]];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_reorder_buffer
// Description : Self-checking bench for a 4-entry, 4-channel IROB. A table of
//               directed cycles covers wrap, out-of-order completion, channel
//               conflict, exceptions, flush and mid-run reset; a randomized
//               phase compares against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_reorder_buffer;

    localparam int DEPTH = 4;
    localparam int TW    = 2;
    localparam int DW    = 32;
    localparam int WP    = 4;

    logic           clk_i = 1'b0;
    logic           rst_i, flush_i;
    logic           alloc_valid_i, alloc_ready_o;
    logic [31:0]    alloc_addr_i;
    logic [4:0]     alloc_reg_dest_i;
    logic [TW-1:0]  alloc_tag_o;
    logic [WP-1:0]  wb_valid_i;
    logic [WP*TW-1:0] wb_tag_i;
    logic [WP*DW-1:0] wb_result_i;
    logic [WP-1:0]  wb_exception_i;
    logic [WP*4-1:0] wb_exc_vector_i;
    logic           commit_valid_o, commit_ready_i;
    logic [TW-1:0]  commit_tag_o;
    logic [31:0]    commit_addr_o;
    logic [4:0]     commit_reg_dest_o;
    logic [DW-1:0]  commit_result_o;
    logic           commit_exception_o;
    logic [3:0]     commit_exc_vector_o;
    logic           full_o, empty_o;

    always #5 clk_i = ~clk_i;

    instruction_reorder_buffer #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .WB_PORTS(WP)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_addr_i(alloc_addr_i), .alloc_reg_dest_i(alloc_reg_dest_i),
        .alloc_tag_o(alloc_tag_o),
        .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_result_i(wb_result_i),
        .wb_exception_i(wb_exception_i), .wb_exc_vector_i(wb_exc_vector_i),
        .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i),
        .commit_tag_o(commit_tag_o), .commit_addr_o(commit_addr_o),
        .commit_reg_dest_o(commit_reg_dest_o), .commit_result_o(commit_result_o),
        .commit_exception_o(commit_exception_o), .commit_exc_vector_o(commit_exc_vector_o),
        .full_o(full_o), .empty_o(empty_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Directed vector: inputs for one cycle and the outputs expected before
    // the clock edge that consumes them. wbt holds 2-bit tags per channel,
    // wbr holds an 8-bit result per channel (zero-extended on the bus).
    typedef struct {
        logic        rst, flush, av, cr;
        logic [3:0]  wbv;
        logic [7:0]  wbt;
        logic [31:0] wbr;
        logic [3:0]  wbe;
        logic [15:0] wbvec;
        logic        e_rdy;
        logic [1:0]  e_tag;
        logic        e_cv;
        logic [1:0]  e_ctag;
        logic [7:0]  e_cres;
        logic        e_exc;
        logic [3:0]  e_vec;
        logic        e_empty, e_full;
    } vec_t;

    vec_t tbl[$];

    // Reference model: in-order queue of live entries.
    typedef struct {
        logic [1:0]  tag;
        logic [31:0] addr;
        logic [4:0]  dest;
        bit          done;
        logic [31:0] res;
        logic        exc;
        logic [3:0]  vec;
    } ment_t;

    ment_t mq[$];
    int    m_next;

    task automatic idle_inputs();
        rst_i = 0; flush_i = 0; alloc_valid_i = 0; commit_ready_i = 0;
        alloc_addr_i = '0; alloc_reg_dest_i = '0;
        wb_valid_i = '0; wb_tag_i = '0; wb_result_i = '0;
        wb_exception_i = '0; wb_exc_vector_i = '0;
    endtask

    initial begin
        idle_inputs();
        rst_i = 1;
        @(posedge clk_i); @(posedge clk_i); #1;

        //          rst fl av cr  wbv      wbt    wbr            wbe      wbvec     rdy tag cv ctag cres  exc vec emp full
        tbl.push_back('{1, 0, 0, 0, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 0, 0, 0, 8'h00, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 2, 0, 0, 8'h00, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 3, 0, 0, 8'h00, 0, 0, 0, 0});
        // full: alloc refused; tag 2 completes first
        tbl.push_back('{0, 0, 1, 0, 4'b0010, 8'h08, 32'h00000C00, 4'b0000, 16'h0000, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 4'b0001, 8'h00, 32'h0000000A, 4'b0000, 16'h0000, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1});
        // full with commit: commit taken, alloc refused
        tbl.push_back('{0, 0, 1, 1, 4'b1000, 8'h40, 32'h0B000000, 4'b0000, 16'h0000, 0, 0, 1, 0, 8'h0A, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 1, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 0, 1, 1, 8'h0B, 0, 0, 0, 0});
        // stall commit, wrap-around alloc gets tag 0
        tbl.push_back('{0, 0, 1, 0, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 0, 1, 2, 8'h0C, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 1, 1, 2, 8'h0C, 0, 0, 0, 0});
        // ch0 and ch2 hit tag 3 (ch0 wins); ch1 reports exception 2 on tag 0
        tbl.push_back('{0, 0, 0, 0, 4'b0111, 8'h33, 32'h00223311, 4'b0010, 16'h0020, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 1, 1, 3, 8'h11, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 1, 1, 0, 8'h33, 1, 2, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 2, 1, 0, 8'h33, 1, 2, 0, 0});
        // flush with 3 pending, commit/alloc blocked in that cycle
        tbl.push_back('{0, 1, 1, 1, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 0, 3, 0, 0, 8'h00, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 0, 0, 0, 8'h00, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 0, 0, 0, 8'h00, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 4'b0001, 8'h00, 32'h00000044, 4'b0000, 16'h0000, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 4'b0100, 8'h10, 32'h00550000, 4'b0000, 16'h0000, 1, 2, 1, 0, 8'h44, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 2, 1, 0, 8'h44, 0, 0, 0, 0});
        // mid-run reset with two done entries, then stale writeback
        tbl.push_back('{1, 0, 0, 0, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 0, 2, 0, 0, 8'h00, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 4'b0001, 8'h00, 32'h00000066, 4'b0000, 16'h0000, 1, 0, 0, 0, 8'h00, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 0, 0, 0, 8'h00, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 4'b0000, 8'h00, 32'h00000000, 4'b0000, 16'h0000, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            rst_i            = tbl[i].rst;
            flush_i          = tbl[i].flush;
            alloc_valid_i    = tbl[i].av;
            commit_ready_i   = tbl[i].cr;
            alloc_addr_i     = 32'h1000 + 32'(i);
            alloc_reg_dest_i = 5'(i);
            wb_valid_i       = tbl[i].wbv;
            wb_tag_i         = tbl[i].wbt;
            wb_exception_i   = tbl[i].wbe;
            wb_exc_vector_i  = tbl[i].wbvec;
            for (int p = 0; p < WP; p++)
                wb_result_i[p*DW +: DW] = {24'h0, tbl[i].wbr[p*8 +: 8]};
            #1;
            chk($sformatf("row%0d alloc_ready", i), 64'(alloc_ready_o), 64'(tbl[i].e_rdy));
            chk($sformatf("row%0d alloc_tag", i),   64'(alloc_tag_o),   64'(tbl[i].e_tag));
            chk($sformatf("row%0d commit_valid", i), 64'(commit_valid_o), 64'(tbl[i].e_cv));
            chk($sformatf("row%0d empty", i),       64'(empty_o),       64'(tbl[i].e_empty));
            chk($sformatf("row%0d full", i),        64'(full_o),        64'(tbl[i].e_full));
            if (tbl[i].e_cv) begin
                chk($sformatf("row%0d commit_tag", i), 64'(commit_tag_o), 64'(tbl[i].e_ctag));
                chk($sformatf("row%0d commit_result", i), 64'(commit_result_o), 64'(tbl[i].e_cres));
                chk($sformatf("row%0d commit_exc", i), 64'(commit_exception_o), 64'(tbl[i].e_exc));
                chk($sformatf("row%0d commit_vec", i), 64'(commit_exc_vector_o), 64'(tbl[i].e_vec));
            end
            @(posedge clk_i); #1;
        end

        // Randomized phase against the queue model
        idle_inputs();
        rst_i = 1;
        @(posedge clk_i); #1;
        mq.delete();
        m_next = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            int  cr_pct;
            bit  e_rdy, e_cv;
            logic [DEPTH-1:0] claimed;

            cr_pct = ((cyc / 250) % 2 == 1) ? 25 : 80;
            rst_i            = ($urandom_range(0, 299) == 0);
            flush_i          = ($urandom_range(0, 149) == 0);
            alloc_valid_i    = ($urandom_range(0, 99) < 70);
            commit_ready_i   = ($urandom_range(0, 99) < cr_pct);
            alloc_addr_i     = $urandom;
            alloc_reg_dest_i = 5'($urandom);
            for (int p = 0; p < WP; p++) begin
                wb_valid_i[p] = ($urandom_range(0, 99) < 40);
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    wb_tag_i[p*TW +: TW] = mq[$urandom_range(0, mq.size() - 1)].tag;
                else
                    wb_tag_i[p*TW +: TW] = 2'($urandom_range(0, 3));
                wb_result_i[p*DW +: DW]   = $urandom;
                wb_exception_i[p]         = ($urandom_range(0, 7) == 0);
                wb_exc_vector_i[p*4 +: 4] = 4'($urandom);
            end
            #1;

            e_rdy = (mq.size() < DEPTH) && !rst_i && !flush_i;
            e_cv  = (mq.size() > 0) && mq[0].done && !rst_i && !flush_i;
            chk("rnd alloc_ready",  64'(alloc_ready_o),  64'(e_rdy));
            chk("rnd alloc_tag",    64'(alloc_tag_o),    64'(m_next));
            chk("rnd commit_valid", 64'(commit_valid_o), 64'(e_cv));
            chk("rnd empty",        64'(empty_o),        64'(mq.size() == 0));
            chk("rnd full",         64'(full_o),         64'(mq.size() == DEPTH));
            if (e_cv) begin
                chk("rnd commit_tag",    64'(commit_tag_o),        64'(mq[0].tag));
                chk("rnd commit_addr",   64'(commit_addr_o),       64'(mq[0].addr));
                chk("rnd commit_dest",   64'(commit_reg_dest_o),   64'(mq[0].dest));
                chk("rnd commit_result", 64'(commit_result_o),     64'(mq[0].res));
                chk("rnd commit_exc",    64'(commit_exception_o),  64'(mq[0].exc));
                chk("rnd commit_vec",    64'(commit_exc_vector_o), 64'(mq[0].vec));
            end

            if (rst_i || flush_i) begin
                mq.delete();
                m_next = 0;
            end else begin
                claimed = '0;
                for (int p = 0; p < WP; p++) begin
                    if (wb_valid_i[p]) begin
                        for (int k = 0; k < mq.size(); k++) begin
                            if (mq[k].tag == wb_tag_i[p*TW +: TW] && !claimed[mq[k].tag]) begin
                                claimed[mq[k].tag] = 1'b1;
                                mq[k].done = 1'b1;
                                mq[k].res  = wb_result_i[p*DW +: DW];
                                mq[k].exc  = wb_exception_i[p];
                                mq[k].vec  = wb_exc_vector_i[p*4 +: 4];
                            end
                        end
                    end
                end
                if (e_cv && commit_ready_i)
                    void'(mq.pop_front());
                if (e_rdy && alloc_valid_i) begin
                    mq.push_back('{tag: 2'(m_next), addr: alloc_addr_i, dest: alloc_reg_dest_i,
                                   done: 1'b0, res: '0, exc: 1'b0, vec: '0});
                    m_next = (m_next + 1) % DEPTH;
                end
            end
            @(posedge clk_i); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
